ifft_4point: RTL and testbench

- Radix-2 4-point inverse DFT. It turns spectrum samples (WIDTH+2 bits, as produced by the forward 4-point FFT) back into WIDTH-bit time-domain samples.
- Applies the 1/N (÷4) scaling internally, then saturates to WIDTH bits.
- Start/done handshake; inputs are captured on accept, so the source may change them immediately afterwards.
- Sits on the return path after the forward transform and any frequency-domain processing.

---
 rtl/ifft_4point.sv | 187 ++++++++++++++++++
 tb/tb_ifft_4point.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_4point.sv
// 4-point radix-2 inverse DFT with divide-by-4 scaling and saturation to WIDTH bits.
// Handshake: start is accepted in IDLE, and done pulses three edges after the accepting edge.
module ifft_4point #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH+1:0] X_real_0,
    input  logic signed [WIDTH+1:0] X_real_1,
    input  logic signed [WIDTH+1:0] X_real_2,
    input  logic signed [WIDTH+1:0] X_real_3,
    input  logic signed [WIDTH+1:0] X_imag_0,
    input  logic signed [WIDTH+1:0] X_imag_1,
    input  logic signed [WIDTH+1:0] X_imag_2,
    input  logic signed [WIDTH+1:0] X_imag_3,
    output logic signed [WIDTH-1:0] x_real_0,
    output logic signed [WIDTH-1:0] x_real_1,
    output logic signed [WIDTH-1:0] x_real_2,
    output logic signed [WIDTH-1:0] x_real_3,
    output logic signed [WIDTH-1:0] x_imag_0,
    output logic signed [WIDTH-1:0] x_imag_1,
    output logic signed [WIDTH-1:0] x_imag_2,
    output logic signed [WIDTH-1:0] x_imag_3,
    output logic                    done,
    output logic                    busy,
    output logic                    sat
);
    localparam int CW = WIDTH + 2;
    localparam int AW = WIDTH + 3;
    localparam int SW = WIDTH + 4;
    localparam logic signed [SW-1:0] S_MAX = {5'b00000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {5'b11111, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_STAGE1, ST_STAGE2, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;
    logic                    cap_en, a_en, out_en;
    logic signed [CW-1:0]    in_re [4];
    logic signed [CW-1:0]    in_im [4];
    logic signed [CW-1:0]    cap_re_q [4];
    logic signed [CW-1:0]    cap_im_q [4];
    logic signed [AW-1:0]    a_re_q [4], a_re_d [4];
    logic signed [AW-1:0]    a_im_q [4], a_im_d [4];
    logic signed [SW-1:0]    s_re [4], s_im [4];
    logic signed [WIDTH-1:0] x_re_q [4], x_re_d [4];
    logic signed [WIDTH-1:0] x_im_q [4], x_im_d [4];
    logic [7:0]              clip_v;

    assign in_re[0] = X_real_0;
    assign in_re[1] = X_real_1;
    assign in_re[2] = X_real_2;
    assign in_re[3] = X_real_3;
    assign in_im[0] = X_imag_0;
    assign in_im[1] = X_imag_1;
    assign in_im[2] = X_imag_2;
    assign in_im[3] = X_imag_3;

    function automatic logic signed [AW-1:0] ext_c(input logic signed [CW-1:0] v);
        return {v[CW-1], v};
    endfunction

    function automatic logic signed [SW-1:0] ext_a(input logic signed [AW-1:0] v);
        return {v[AW-1], v};
    endfunction

    // Returns {clipped, value}: floor divide by 4, then clamp to the WIDTH-bit range.
    function automatic logic [WIDTH:0] scale_clip(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = s >>> 2;
        if (sh > S_MAX) return {1'b1, W_MAX};
        if (sh < S_MIN) return {1'b1, W_MIN};
        return {1'b0, sh[WIDTH-1:0]};
    endfunction

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        a_en    = 1'b0;
        out_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_en  = 1'b1;
                    state_d = ST_STAGE1;
                end
            end
            ST_STAGE1: begin
                a_en    = 1'b1;
                state_d = ST_STAGE2;
            end
            ST_STAGE2: begin
                out_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_re_d[0] = ext_c(cap_re_q[0]) + ext_c(cap_re_q[2]);
        a_im_d[0] = ext_c(cap_im_q[0]) + ext_c(cap_im_q[2]);
        a_re_d[1] = ext_c(cap_re_q[1]) + ext_c(cap_re_q[3]);
        a_im_d[1] = ext_c(cap_im_q[1]) + ext_c(cap_im_q[3]);
        a_re_d[2] = ext_c(cap_re_q[0]) - ext_c(cap_re_q[2]);
        a_im_d[2] = ext_c(cap_im_q[0]) - ext_c(cap_im_q[2]);
        a_re_d[3] = ext_c(cap_re_q[1]) - ext_c(cap_re_q[3]);
        a_im_d[3] = ext_c(cap_im_q[1]) - ext_c(cap_im_q[3]);
    end

    // Odd bins rotate a3 by +j (bin 1) or -j (bin 3) before combining with a2.
    always_comb begin
        s_re[0] = ext_a(a_re_q[0]) + ext_a(a_re_q[1]);
        s_im[0] = ext_a(a_im_q[0]) + ext_a(a_im_q[1]);
        s_re[2] = ext_a(a_re_q[0]) - ext_a(a_re_q[1]);
        s_im[2] = ext_a(a_im_q[0]) - ext_a(a_im_q[1]);
        s_re[1] = ext_a(a_re_q[2]) - ext_a(a_im_q[3]);
        s_im[1] = ext_a(a_im_q[2]) + ext_a(a_re_q[3]);
        s_re[3] = ext_a(a_re_q[2]) + ext_a(a_im_q[3]);
        s_im[3] = ext_a(a_im_q[2]) - ext_a(a_re_q[3]);
        clip_v  = '0;
        for (int k = 0; k < 4; k++) begin
            {clip_v[k], x_re_d[k]}     = scale_clip(s_re[k]);
            {clip_v[k + 4], x_im_d[k]} = scale_clip(s_im[k]);
        end
        sat_d = |clip_v;
    end

    // NOTE: the small capture/stage arrays are reset too, so an abandoned
    // transform leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cap_re_q[k] <= '0;
                cap_im_q[k] <= '0;
                a_re_q[k]   <= '0;
                a_im_q[k]   <= '0;
                x_re_q[k]   <= '0;
                x_im_q[k]   <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            for (int k = 0; k < 4; k++) begin
                if (cap_en) begin
                    cap_re_q[k] <= in_re[k];
                    cap_im_q[k] <= in_im[k];
                end
                if (a_en) begin
                    a_re_q[k] <= a_re_d[k];
                    a_im_q[k] <= a_im_d[k];
                end
                if (out_en) begin
                    x_re_q[k] <= x_re_d[k];
                    x_im_q[k] <= x_im_d[k];
                end
            end
            if (out_en) sat_q <= sat_d;
        end
    end

    assign x_real_0 = x_re_q[0];
    assign x_real_1 = x_re_q[1];
    assign x_real_2 = x_re_q[2];
    assign x_real_3 = x_re_q[3];
    assign x_imag_0 = x_im_q[0];
    assign x_imag_1 = x_im_q[1];
    assign x_imag_2 = x_im_q[2];
    assign x_imag_3 = x_im_q[3];
    assign done     = done_q;
    assign sat      = sat_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifft_4point.sv
// Self-checking bench for ifft_4point: table vectors, handshake sequences, and randomized
// transforms compared against a direct inverse-DFT summation model.
module tb_ifft_4point;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [17:0]  xr_i [4];
    logic signed [17:0]  xi_i [4];
    logic signed [15:0]  xr_o [4];
    logic signed [15:0]  xi_o [4];
    logic                done, busy, sat;

    int pass_cnt = 0;
    int total_cnt = 0;
    int stim_r [4];
    int stim_i [4];

    typedef struct packed {
        logic [3:0][17:0] r;
        logic [3:0][17:0] i;
        logic [3:0][15:0] er;
        logic             es;
    } vec_t;

    always #5 clk = ~clk;

    ifft_4point #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .X_real_0(xr_i[0]), .X_real_1(xr_i[1]), .X_real_2(xr_i[2]), .X_real_3(xr_i[3]),
        .X_imag_0(xi_i[0]), .X_imag_1(xi_i[1]), .X_imag_2(xi_i[2]), .X_imag_3(xi_i[3]),
        .x_real_0(xr_o[0]), .x_real_1(xr_o[1]), .x_real_2(xr_o[2]), .x_real_3(xr_o[3]),
        .x_imag_0(xi_o[0]), .x_imag_1(xi_o[1]), .x_imag_2(xi_o[2]), .x_imag_3(xi_o[3]),
        .done(done), .busy(busy), .sat(sat)
    );

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // x[n] = floor((1/4) * sum_k X[k] * j^(n*k)), then clamped to 16-bit signed.
    task automatic model(output int er [4], output int ei [4], output int es);
        int sr, si;
        es = 0;
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                case ((n * k) % 4)
                    0: begin sr += stim_r[k]; si += stim_i[k]; end
                    1: begin sr -= stim_i[k]; si += stim_r[k]; end
                    2: begin sr -= stim_r[k]; si -= stim_i[k]; end
                    default: begin sr += stim_i[k]; si -= stim_r[k]; end
                endcase
            end
            sr = sr >>> 2;
            si = si >>> 2;
            if (sr > 32767) begin sr = 32767; es = 1; end
            if (sr < -32768) begin sr = -32768; es = 1; end
            if (si > 32767) begin si = 32767; es = 1; end
            if (si < -32768) begin si = -32768; es = 1; end
            er[n] = sr;
            ei[n] = si;
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < 4; k++) begin
            xr_i[k] = 18'($urandom);
            xi_i[k] = 18'($urandom);
        end
    endtask

    task automatic drive_stim();
        for (int k = 0; k < 4; k++) begin
            xr_i[k] = 18'(stim_r[k]);
            xi_i[k] = 18'(stim_i[k]);
        end
    endtask

    task automatic check_outputs(input string name, input int er [4], input int ei [4], input int es);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s x_real_%0d", name, k), int'(xr_o[k]), er[k]);
            check($sformatf("%s x_imag_%0d", name, k), int'(xi_o[k]), ei[k]);
        end
        check($sformatf("%s sat", name), int'(sat), es);
    endtask

    // One transform from stim_*; inputs are scrambled right after accept and, when
    // disturb is set, start is re-asserted with junk data during STAGE1 and STAGE2.
    task automatic run_xform(input string name, input int er [4], input int ei [4],
                             input int es, input bit disturb);
        @(negedge clk);
        drive_stim();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        check($sformatf("%s busy@T", name), int'(busy), 1);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            start = disturb && (e <= 2);
            if (start) scramble();
            @(posedge clk);
            #1;
            check($sformatf("%s done@T+%0d", name, e), int'(done), int'(e == 3));
            check($sformatf("%s busy@T+%0d", name, e), int'(busy), int'(e < 3));
        end
        check_outputs(name, er, ei, es);
        @(posedge clk);
        #1;
        check($sformatf("%s done cleared", name), int'(done), 0);
    endtask

    function automatic vec_t mk(input int r0, r1, r2, r3, i0, i1, i2, i3,
                                input int e0, e1, e2, e3, input logic es);
        vec_t v;
        v.r[0] = 18'(r0); v.r[1] = 18'(r1); v.r[2] = 18'(r2); v.r[3] = 18'(r3);
        v.i[0] = 18'(i0); v.i[1] = 18'(i1); v.i[2] = 18'(i2); v.i[3] = 18'(i3);
        v.er[0] = 16'(e0); v.er[1] = 16'(e1); v.er[2] = 16'(e2); v.er[3] = 16'(e3);
        v.es = es;
        return v;
    endfunction

    initial begin
        vec_t vecs [7];
        int   er [4], ei [4], es, zero [4], pulses, last_edge, gap_ok;
        logic signed [17:0] t;

        vecs[0] = mk(10, -2, -2, -2,  0, 2, 0, -2,  1, 2, 3, 4,  1'b0);
        vecs[1] = mk(4, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1,  1'b0);
        vecs[2] = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1'b0);
        vecs[3] = mk(-1, 0, 0, 0,  0, 0, 0, 0,  -1, -1, -1, -1,  1'b0);
        vecs[4] = mk(131071, 131071, 131071, 131071,  0, 0, 0, 0,  32767, 0, 0, 0,  1'b1);
        vecs[5] = mk(-131072, -131072, -131072, -131072,  0, 0, 0, 0,  -32768, 0, 0, 0,  1'b1);
        vecs[6] = mk(10, -2, -2, -2,  0, 2, 0, -2,  1, 2, 3, 4,  1'b0);
        zero = '{0, 0, 0, 0};

        for (int k = 0; k < 4; k++) begin
            xr_i[k] = '0;
            xi_i[k] = '0;
        end
        #3;
        check_outputs("reset", zero, zero, 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 4; k++) begin
                stim_r[k] = int'($signed(vecs[v].r[k]));
                stim_i[k] = int'($signed(vecs[v].i[k]));
                er[k]     = int'($signed(vecs[v].er[k]));
            end
            run_xform($sformatf("vec%0d", v), er, zero, int'(vecs[v].es), v == 0);
        end

        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (n % 2 == 0) begin
                    t = 18'($urandom);
                    stim_r[k] = int'(t);
                    t = 18'($urandom);
                    stim_i[k] = int'(t);
                end else begin
                    stim_r[k] = int'($urandom_range(0, 4000)) - 2000;
                    stim_i[k] = int'($urandom_range(0, 4000)) - 2000;
                end
            end
            model(er, ei, es);
            run_xform($sformatf("rand%0d", n), er, ei, es, 1'($urandom));
        end

        // start held high for 12 edges: accepts at edges 1, 5, 9 and done after 4, 8, 12.
        stim_r = '{10, -2, -2, -2};
        stim_i = '{0, 2, 0, -2};
        model(er, ei, es);
        @(negedge clk);
        drive_stim();
        start = 1'b1;
        pulses = 0;
        last_edge = 0;
        gap_ok = 1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (e - last_edge != 4) gap_ok = 0;
                last_edge = e;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held start pulses", pulses, 3);
        check("held start spacing", gap_ok, 1);
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("held start quiet after release", pulses, 3);
        check_outputs("held start", er, ei, es);

        // Reset during STAGE2 after a saturating transform left nonzero outputs and sat = 1.
        stim_r = '{131071, 131071, 131071, 131071};
        stim_i = '{0, 0, 0, 0};
        model(er, ei, es);
        run_xform("pre-reset", er, ei, es, 1'b0);
        stim_r = '{10, -2, -2, -2};
        stim_i = '{0, 2, 0, -2};
        @(negedge clk);
        drive_stim();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("async reset", zero, zero, 0);
        check("async reset done", int'(done), 0);
        check("async reset busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("no done after abandoned transform", pulses, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
